mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped bus controller between the `cpu` memory port (`mem_cmd`/`mem_addr`) and the data RAM plus a bank of I/O registers. It generalises the fixed LED/switch decode to NOUT output registers and NIN synchronised input ports, and adds a multi-cycle access FSM with RAM wait states and a `mem_ready` handshake. It also provides a status register with per-input change flags and a sticky bad-address flag. It sits at top level and replaces the combinational tri-state decode.

---
 rtl/mmio_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: routes cpu accesses to RAM (with wait states) or an I/O register bank.
// Multi-cycle FSM IDLE->RAM/IO->RESP; mem_ready pulses for one cycle; commands are only sampled in IDLE.
module mmio_bus_ctrl #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int NOUT     = 2,
  parameter int NIN      = 2,
  parameter int RAM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mem_cmd,
  input  logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_wdata,
  output logic [DW-1:0]       mem_rdata,
  output logic                mem_ready,
  output logic [AW-2:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  output logic                ram_write,
  input  logic [DW-1:0]       ram_rdata,
  output logic [NOUT*DW-1:0]  out_port,
  input  logic [NIN*DW-1:0]   in_port
);

  localparam int IW = AW - 3;
  localparam int CW = (RAM_WAIT > 0) ? $clog2(RAM_WAIT + 1) : 1;
  localparam logic [IW:0] NOUT_W = (IW + 1)'(NOUT);
  localparam logic [IW:0] NIN_W  = (IW + 1)'(NIN);

  typedef enum logic [1:0] {S_IDLE, S_RAM, S_IO, S_RESP} state_e;

  state_e state_q, state_d;

  logic                      wr_q;
  logic [AW-1:0]             addr_q;
  logic [DW-1:0]             wdata_q;
  logic [DW-1:0]             rdata_q;
  logic [CW-1:0]             cnt_q;
  logic [NOUT-1:0][DW-1:0]   out_q;
  logic [NIN-1:0][DW-1:0]    sync1_q, sync2_q, prev_q;
  logic [NIN-1:0]            chg_q, chg_d;
  logic                      err_q, err_d;

  logic                      cmd_vld;
  logic [1:0]                fld;
  logic [IW-1:0]             idx;
  logic                      out_hit, in_hit, st_hit, io_bad, io_act;
  logic [NOUT-1:0]           out_sel;
  logic [NIN-1:0]            in_sel;
  logic [DW-1:0]             io_rdata;

  assign cmd_vld = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);

  assign fld     = addr_q[AW-2:AW-3];
  assign idx     = addr_q[IW-1:0];
  assign out_hit = (fld == 2'b00) && ({1'b0, idx} < NOUT_W);
  assign in_hit  = (fld == 2'b01) && ({1'b0, idx} < NIN_W);
  assign st_hit  = (fld == 2'b10);
  // Reads of the in bank are legal, writes to it are not.
  assign io_bad  = !(out_hit || (in_hit && !wr_q) || st_hit);
  assign io_act  = (state_q == S_IO);

  always_comb begin
    out_sel = '0;
    in_sel  = '0;
    for (int k = 0; k < NOUT; k++) out_sel[k] = out_hit && (idx == IW'(k));
    for (int k = 0; k < NIN; k++)  in_sel[k]  = in_hit && (idx == IW'(k));
  end

  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < NOUT; k++) if (out_sel[k]) io_rdata = out_q[k];
    for (int k = 0; k < NIN; k++)  if (in_sel[k])  io_rdata = sync2_q[k];
    if (st_hit) begin
      io_rdata[NIN-1:0] = chg_q;
      io_rdata[DW-1]    = err_q;
    end
  end

  // Clears are applied first so that a change detected in the same cycle wins.
  always_comb begin
    chg_d = chg_q;
    err_d = err_q;
    for (int k = 0; k < NIN; k++) begin
      if (io_act && !wr_q && in_sel[k])            chg_d[k] = 1'b0;
      if (io_act && wr_q && st_hit && wdata_q[k])  chg_d[k] = 1'b0;
      if (sync2_q[k] != prev_q[k])                 chg_d[k] = 1'b1;
    end
    if (io_act && wr_q && st_hit && wdata_q[DW-1]) err_d = 1'b0;
    if (io_act && io_bad)                          err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_vld) state_d = mem_addr[AW-1] ? S_IO : S_RAM;
      S_RAM:   if (cnt_q == '0) state_d = S_RESP;
      S_IO:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == S_RESP);
    ram_write = (state_q == S_RAM) && wr_q && (cnt_q == CW'(RAM_WAIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      chg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      chg_q   <= chg_d;
      err_q   <= err_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_vld) begin
            wr_q    <= (mem_cmd == 2'b10);
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= CW'(RAM_WAIT);
          end
        end
        S_RAM: begin
          if (cnt_q == '0) begin
            if (!wr_q) rdata_q <= ram_rdata;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_IO: begin
          if (!wr_q) rdata_q <= io_rdata;
          for (int k = 0; k < NOUT; k++) begin
            if (wr_q && out_sel[k]) out_q[k] <= wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign ram_addr  = addr_q[AW-2:0];
  assign ram_wdata = wdata_q;
  assign out_port  = out_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized bench for mmio_bus_ctrl against an access-level reference model of the memory map.
module tb_mmio_bus_ctrl;
  localparam int AW = 9, DW = 16, NOUT = 2, NIN = 2, RAM_WAIT = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          mem_cmd;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                mem_ready;
  logic [AW-2:0]       ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic                ram_write;
  logic [DW-1:0]       ram_rdata;
  logic [NOUT*DW-1:0]  out_port;
  logic [NIN*DW-1:0]   in_port;

  mmio_bus_ctrl #(.AW(AW), .DW(DW), .NOUT(NOUT), .NIN(NIN), .RAM_WAIT(RAM_WAIT)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
    .ram_rdata(ram_rdata), .out_port(out_port), .in_port(in_port)
  );

  always #5 clk = ~clk;

  // Synchronous RAM; unwritten words return a fixed address-derived pattern.
  logic [15:0] ram [256];
  bit          ram_vld [256];

  function automatic logic [15:0] seed(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (ram_write) begin
      ram[ram_addr]     <= ram_wdata;
      ram_vld[ram_addr] <= 1'b1;
    end
    ram_rdata <= ram_vld[ram_addr] ? ram[ram_addr] : seed(ram_addr);
  end

  // Reference model state
  logic [15:0] mdl_ram [256];
  logic [15:0] mdl_out [NOUT];
  logic [15:0] mdl_last_in [NIN];
  bit          mdl_chg [NIN];
  bit          mdl_err;
  logic [15:0] mdl_rdata;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_out_packed();
    logic [31:0] v = '0;
    for (int k = 0; k < NOUT; k++) v[k*16 +: 16] = mdl_out[k];
    return v;
  endfunction

  function automatic logic [15:0] mdl_status();
    logic [15:0] s = '0;
    for (int k = 0; k < NIN; k++) s[k] = mdl_chg[k];
    s[15] = mdl_err;
    return s;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < NOUT; k++) mdl_out[k] = '0;
    for (int k = 0; k < NIN; k++) begin mdl_last_in[k] = '0; mdl_chg[k] = 0; end
    mdl_err   = 0;
    mdl_rdata = '0;
  endtask

  // Effect of one complete access on the memory map, plus its expected timing.
  task automatic model_access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                              output logic [15:0] rd, output int lat, output int wcnt);
    bit wr  = (cmd == 2'b10);
    bit bad = 0;
    int idx = int'(addr[5:0]);
    wcnt = 0;
    if (!addr[8]) begin
      lat = RAM_WAIT + 2;
      if (wr) begin mdl_ram[addr[7:0]] = wd; wcnt = 1; end
      else mdl_rdata = mdl_ram[addr[7:0]];
    end else begin
      lat = 2;
      case (addr[7:6])
        2'b00: if (idx < NOUT) begin
                 if (wr) mdl_out[idx] = wd; else mdl_rdata = mdl_out[idx];
               end else bad = 1;
        2'b01: if (idx < NIN && !wr) begin
                 mdl_rdata = mdl_last_in[idx];
                 mdl_chg[idx] = 0;
               end else bad = 1;
        2'b10: if (wr) begin
                 for (int k = 0; k < NIN; k++) if (wd[k]) mdl_chg[k] = 0;
                 if (wd[15]) mdl_err = 0;
               end else mdl_rdata = mdl_status();
        default: bad = 1;
      endcase
      if (bad) begin
        mdl_err = 1;
        if (!wr) mdl_rdata = '0;
      end
    end
    rd = mdl_rdata;
  endtask

  task automatic dut_access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat, output int wcnt);
    bit rdy = 0;
    @(negedge clk);
    mem_cmd = cmd; mem_addr = addr; mem_wdata = wd;
    lat = 0; wcnt = 0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_write) wcnt++;
      rdy = mem_ready;
    end
    rd = mem_rdata;
    mem_cmd = 2'b00;
  endtask

  task automatic do_op(input string tag, input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    logic [15:0] er, r;
    int el, ew, l, w;
    model_access(cmd, addr, wd, er, el, ew);
    dut_access(cmd, addr, wd, r, l, w);
    check({tag, " rdata"}, r, er);
    check({tag, " lat"}, l, el);
    check({tag, " ram_write"}, w, ew);
    check({tag, " out_port"}, out_port, mdl_out_packed());
  endtask

  task automatic set_input(input int k, input logic [15:0] v);
    @(negedge clk);
    in_port[k*16 +: 16] = v;
    repeat (4) @(negedge clk);
    if (v != mdl_last_in[k]) mdl_chg[k] = 1;
    mdl_last_in[k] = v;
  endtask

  initial begin
    logic [15:0] er, r, wd;
    logic [8:0]  a;
    logic [1:0]  c;
    int el, ew, l, w;

    for (int i = 0; i < 256; i++) mdl_ram[i] = seed(8'(i));
    mdl_reset();
    reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; mem_wdata = '0; in_port = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst mem_ready", mem_ready, 0);
    check("rst mem_rdata", mem_rdata, 0);
    check("rst ram_write", ram_write, 0);
    check("rst out_port", out_port, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_wdata", ram_wdata, 0);

    do_op("wr_out0", 2'b10, 9'h100, 16'h00A5);
    do_op("ram_wr5", 2'b10, 9'h005, 16'h1234);
    do_op("ram_rd5", 2'b01, 9'h005, 16'h0000);

    set_input(0, 16'h0055);
    do_op("status_chg", 2'b01, 9'h180, 16'h0);
    do_op("rd_in0", 2'b01, 9'h140, 16'h0);
    do_op("status_clr", 2'b01, 9'h180, 16'h0);

    do_op("rd_unmapped", 2'b01, 9'h1C0, 16'h0);
    do_op("status_err", 2'b01, 9'h180, 16'h0);
    do_op("w1c_err", 2'b10, 9'h180, 16'h8000);
    do_op("status_noerr", 2'b01, 9'h180, 16'h0);

    // Input change whose flag-set edge coincides with the read of that port.
    do_op("clr_all", 2'b10, 9'h180, 16'h8003);
    @(negedge clk);
    in_port[15:0] = 16'h00AA;
    mdl_last_in[0] = 16'h00AA;
    model_access(2'b01, 9'h140, 16'h0, er, el, ew);
    mdl_chg[0] = 1;
    dut_access(2'b01, 9'h140, 16'h0, r, l, w);
    check("race rdata", r, er);
    check("race lat", l, el);
    do_op("race_status", 2'b01, 9'h180, 16'h0);

    for (int i = 0; i < 60; i++) begin
      c  = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      wd = 16'($urandom);
      case ($urandom_range(0, 7))
        0: do_op("rnd_ram_wr", 2'b10, {1'b0, 8'($urandom)}, wd);
        1: do_op("rnd_ram_rd", 2'b01, {1'b0, 8'($urandom)}, wd);
        2: do_op("rnd_out", c, {3'b100, 6'($urandom_range(0, 3))}, wd);
        3: do_op("rnd_in", c, {3'b101, 6'($urandom_range(0, 3))}, wd);
        4: do_op("rnd_st_rd", 2'b01, 9'h180, wd);
        5: do_op("rnd_st_wr", 2'b10, 9'h180, wd);
        6: do_op("rnd_unmap", c, {3'b111, 6'($urandom)}, wd);
        default: set_input($urandom_range(0, NIN - 1), wd);
      endcase
    end

    // Reset during the first RAM cycle of a write must drop the write and the response.
    set_input(0, 16'h0000);
    set_input(1, 16'h0000);
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h010; mem_wdata = 16'hBEEF;
    @(negedge clk);
    check("pre_rst ram_write", ram_write, 1);
    reset = 1'b1;
    mem_cmd = 2'b00;
    mdl_reset();
    repeat (2) begin
      @(negedge clk);
      check("abort mem_ready", mem_ready, 0);
      check("abort ram_write", ram_write, 0);
    end
    check("abort out_port", out_port, 0);
    check("abort mem_rdata", mem_rdata, 0);
    check("abort ram_addr", ram_addr, 0);
    check("abort ram_wdata", ram_wdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort ram[10]", ram_vld[8'h10] ? ram[8'h10] : seed(8'h10), mdl_ram[8'h10]);
    do_op("post_rst_status", 2'b01, 9'h180, 16'h0);
    do_op("post_rst_rd10", 2'b01, 9'h010, 16'h0);
    do_op("post_rst_out1", 2'b01, 9'h101, 16'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
